// File: rtl/fft_output_reader_if.sv
// ---------------------------------------------------------------------------
// fft_output_reader_if
//   Output stream bundle between the FFT read-side sequencer and the result
//   consumer. One word moves when out_valid and out_ready are both high at a
//   rising clock edge.
//
//   out_data   {real,imag} word as stored in the FFT result memory
//   out_index  bin index of out_data
//   out_valid  out_data/out_index/out_last are meaningful
//   out_ready  consumer can take the current word
//   out_last   marks the final bin of the frame
//
//   master: the sequencer (drives data/index/valid/last, samples ready)
//   slave : the consumer  (samples data/index/valid/last, drives ready)
// ---------------------------------------------------------------------------
interface fft_output_reader_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 4
);
  logic [DATA_W-1:0] out_data;
  logic [AW-1:0]     out_index;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_index,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fft_output_reader.sv
// ---------------------------------------------------------------------------
// fft_output_reader
//   Read-side sequencer for the FFT result memory. A start pulse makes it walk
//   addresses 0..N-1 in natural order (N chosen by mode), register each word
//   read from the combinational memory port and stream it to the consumer
//   over a valid/ready handshake.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   start     1-cycle request to stream one frame (ignored while busy)
//   abort     drop the current frame and go idle, no done pulse
//   mode      frame size select: 0:N=4, 1:N=8, 2:N=16, other:N=FFT_SIZE
//   mem_addr  read address to the FFT memory
//   mem_data  combinational read data from the FFT memory
//   busy      high from an accepted start until the frame ends or aborts
//   done      1-cycle pulse after the last word has been accepted
//   out       output stream (master side of fft_output_reader_if)
// ---------------------------------------------------------------------------
module fft_output_reader #(
  parameter int BIT_WIDTH = 8,
  parameter int MODE_NUM  = 3,
  parameter int FFT_SIZE  = 16,
  localparam int AW       = $clog2(FFT_SIZE),
  localparam int MW       = (MODE_NUM > 1) ? $clog2(MODE_NUM) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [MW-1:0]          mode,
  output logic [AW-1:0]          mem_addr,
  input  logic [2*BIT_WIDTH-1:0] mem_data,
  output logic                   busy,
  output logic                   done,
  fft_output_reader_if.master    out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] last_addr;

  // Index of the final bin for a given mode; sizes larger than the memory
  // are clamped so the compare never needs more than AW bits.
  function automatic logic [AW-1:0] last_index(input logic [MW-1:0] m);
    int n;
    case (m)
      MW'(0):  n = 4;
      MW'(1):  n = 8;
      MW'(2):  n = 16;
      default: n = FFT_SIZE;
    endcase
    if (n > FFT_SIZE) n = FFT_SIZE;
    return AW'(n - 1);
  endfunction

  // Single sequencing process. The output register is reloaded whenever it
  // is empty or its word is being taken, so a ready consumer sees one word
  // per cycle while a stalled one sees every output frozen. The address
  // register always points one bin ahead of out_index. Abort is checked
  // first so it beats both a load and a new start in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_addr     <= '0;
      mem_addr      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      out.out_data  <= '0;
      out.out_index <= '0;
      out.out_valid <= 1'b0;
      out.out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state         <= IDLE;
        mem_addr      <= '0;
        busy          <= 1'b0;
        out.out_valid <= 1'b0;
        out.out_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              last_addr <= last_index(mode);
              mem_addr  <= '0;
              busy      <= 1'b1;
              state     <= STREAM;
            end
          end
          STREAM: begin
            if (!out.out_valid || out.out_ready) begin
              out.out_data  <= mem_data;
              out.out_index <= mem_addr;
              out.out_valid <= 1'b1;
              out.out_last  <= (mem_addr == last_addr);
              if (mem_addr == last_addr) begin
                mem_addr <= '0;
                state    <= DRAIN;
              end else begin
                mem_addr <= mem_addr + AW'(1);
              end
            end
          end
          DRAIN: begin
            if (out.out_valid && out.out_ready) begin
              out.out_valid <= 1'b0;
              out.out_last  <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_output_reader.sv
// ---------------------------------------------------------------------------
// tb_fft_output_reader
//   Self-checking bench for fft_output_reader. A behavioural memory feeds the
//   read port; each scenario task predicts the word stream from the frame
//   size, the memory contents and the consumer's ready pattern.
// ---------------------------------------------------------------------------
module tb_fft_output_reader;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode  = 2'd0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [16];

  int compared   = 0;
  int mismatched = 0;

  fft_output_reader_if #(.DATA_W(DW), .AW(AW)) bus ();

  fft_output_reader #(
    .BIT_WIDTH(8),
    .MODE_NUM (3),
    .FFT_SIZE (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .busy    (busy),
    .done    (done),
    .out     (bus)
  );

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  // Frame length implied by a mode value.
  function automatic int frame_len(input logic [1:0] m);
    case (m)
      2'd0:    return 4;
      2'd1:    return 8;
      default: return 16;
    endcase
  endfunction

  task automatic fill_random;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
  endtask

  // Called at a falling edge: presents start for exactly one rising edge and
  // returns at the following falling edge.
  task automatic start_frame(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    compared++;
    if ({mem_addr, bus.out_data, bus.out_index, bus.out_valid, bus.out_last, busy, done} !== '0)
      begin mismatched++; $display("[TB] FAIL reset_values addr=%0d d=%h i=%0d v=%b l=%b busy=%b done=%b want all 0",
        mem_addr, bus.out_data, bus.out_index, bus.out_valid, bus.out_last, busy, done); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b0)
      begin mismatched++; $display("[TB] FAIL idle_after_reset busy=%b v=%b done=%b want 0 0 0", busy, bus.out_valid, done); end
  endtask

  task automatic test_full_frame;
    for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
    bus.out_ready = 1'b1;
    start_frame(2'd2);
    compared++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b1)
      begin mismatched++; $display("[TB] FAIL t1_after_start v=%b busy=%b want 0 1", bus.out_valid, busy); end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      compared++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hA000 + 16'(i) ||
          bus.out_index !== AW'(i) || bus.out_last !== (i == 15))
        begin mismatched++; $display("[TB] FAIL t1_word idx=%0d got v=%b d=%h i=%0d l=%b want d=%h",
          i, bus.out_valid, bus.out_data, bus.out_index, bus.out_last, 16'hA000 + 16'(i)); end
      @(negedge clk);
    end
    compared++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0)
      begin mismatched++; $display("[TB] FAIL t1_done done=%b busy=%b v=%b want 1 0 0", done, busy, bus.out_valid); end
    @(negedge clk);
    compared++;
    if (done !== 1'b0)
      begin mismatched++; $display("[TB] FAIL t1_done_width done=%b want 0", done); end
  endtask

  task automatic test_short_frame;
    int idx;
    fill_random();
    bus.out_ready = 1'b1;
    start_frame(2'd0);
    idx = 0;
    for (int c = 0; c < 12 && idx < 4; c++) begin
      @(negedge clk);
      compared++;
      if (mem_addr > 4'd3)
        begin mismatched++; $display("[TB] FAIL t2_addr_range addr=%0d want <=3", mem_addr); end
      if (bus.out_valid === 1'b1) begin
        compared++;
        if (bus.out_data !== mem[idx] || bus.out_index !== AW'(idx) || bus.out_last !== (idx == 3))
          begin mismatched++; $display("[TB] FAIL t2_word idx=%0d got d=%h i=%0d l=%b want d=%h",
            idx, bus.out_data, bus.out_index, bus.out_last, mem[idx]); end
        idx++;
      end
    end
    compared++;
    if (idx != 4)
      begin mismatched++; $display("[TB] FAIL t2_count got %0d want 4", idx); end
    @(negedge clk);
    compared++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0)
      begin mismatched++; $display("[TB] FAIL t2_done done=%b busy=%b v=%b want 1 0 0", done, busy, bus.out_valid); end
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0 || mem_addr > 4'd3)
      begin mismatched++; $display("[TB] FAIL t2_no_extra v=%b addr=%0d want 0 <=3", bus.out_valid, mem_addr); end
  endtask

  task automatic test_backpressure;
    int idx;
    int stall;
    int seen5;
    fill_random();
    bus.out_ready = 1'b1;
    start_frame(2'd2);
    idx = 0;
    stall = 0;
    seen5 = 0;
    for (int c = 0; c < 200 && idx < 16; c++) begin
      @(negedge clk);
      if (idx == 5 && stall < 3) begin
        bus.out_ready = 1'b0;
        stall++;
      end else if (idx > 5) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid === 1'b1) begin
        if (idx == 5) seen5++;
        compared++;
        if (bus.out_data !== mem[idx] || bus.out_index !== AW'(idx) || bus.out_last !== (idx == 15) ||
            mem_addr !== AW'((idx + 1) % 16))
          begin mismatched++; $display("[TB] FAIL t3_word idx=%0d got d=%h i=%0d l=%b addr=%0d want d=%h addr=%0d",
            idx, bus.out_data, bus.out_index, bus.out_last, mem_addr, mem[idx], (idx + 1) % 16); end
        if (bus.out_ready) idx++;
      end
    end
    compared++;
    if (idx != 16 || seen5 != 4)
      begin mismatched++; $display("[TB] FAIL t3_count words=%0d idx5_cycles=%0d want 16 4", idx, seen5); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (done !== 1'b1 || busy !== 1'b0)
      begin mismatched++; $display("[TB] FAIL t3_done done=%b busy=%b want 1 0", done, busy); end
  endtask

  task automatic test_start_ignored;
    int idx;
    fill_random();
    bus.out_ready = 1'b1;
    start_frame(2'd2);
    idx = 0;
    for (int c = 0; c < 40 && idx < 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.out_valid === 1'b1) begin
        compared++;
        if (bus.out_data !== mem[idx] || bus.out_index !== AW'(idx) || bus.out_last !== (idx == 15))
          begin mismatched++; $display("[TB] FAIL t4_word idx=%0d got d=%h i=%0d l=%b want d=%h",
            idx, bus.out_data, bus.out_index, bus.out_last, mem[idx]); end
        if (idx == 7) begin
          start = 1'b1;
          mode  = 2'd0;
        end
        idx++;
      end
    end
    start = 1'b0;
    compared++;
    if (idx != 16)
      begin mismatched++; $display("[TB] FAIL t4_count got %0d want 16", idx); end
    @(negedge clk);
    compared++;
    if (done !== 1'b1 || busy !== 1'b0)
      begin mismatched++; $display("[TB] FAIL t4_done done=%b busy=%b want 1 0", done, busy); end
    @(negedge clk);
    start_frame(2'd0);
    idx = 0;
    for (int c = 0; c < 12 && idx < 4; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        compared++;
        if (bus.out_data !== mem[idx] || bus.out_index !== AW'(idx) || bus.out_last !== (idx == 3))
          begin mismatched++; $display("[TB] FAIL t4_second_word idx=%0d got d=%h i=%0d l=%b want d=%h",
            idx, bus.out_data, bus.out_index, bus.out_last, mem[idx]); end
        idx++;
      end
    end
    @(negedge clk);
    compared++;
    if (idx != 4 || done !== 1'b1)
      begin mismatched++; $display("[TB] FAIL t4_second_frame words=%0d done=%b want 4 1", idx, done); end
  endtask

  task automatic test_back_to_back;
    int idx;
    fill_random();
    bus.out_ready = 1'b1;
    start_frame(2'd1);
    for (int f = 0; f < 2; f++) begin
      idx = 0;
      for (int c = 0; c < 24 && idx < 8; c++) begin
        @(negedge clk);
        if (bus.out_valid === 1'b1) begin
          compared++;
          if (bus.out_data !== mem[idx] || bus.out_index !== AW'(idx) || bus.out_last !== (idx == 7))
            begin mismatched++; $display("[TB] FAIL b2b_word frame=%0d idx=%0d got d=%h i=%0d l=%b want d=%h",
              f, idx, bus.out_data, bus.out_index, bus.out_last, mem[idx]); end
          idx++;
        end
      end
      @(negedge clk);
      compared++;
      if (idx != 8 || done !== 1'b1)
        begin mismatched++; $display("[TB] FAIL b2b_done frame=%0d words=%0d done=%b want 8 1", f, idx, done); end
      if (f == 0) begin
        start_frame(2'd1);
        compared++;
        if (busy !== 1'b1 || bus.out_valid !== 1'b0)
          begin mismatched++; $display("[TB] FAIL b2b_restart busy=%b v=%b want 1 0", busy, bus.out_valid); end
      end
    end
  endtask

  task automatic test_abort;
    int idx;
    fill_random();
    bus.out_ready = 1'b1;
    start_frame(2'd2);
    idx = 0;
    for (int c = 0; c < 40 && idx < 9; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) idx++;
    end
    @(negedge clk);
    compared++;
    if (bus.out_index !== 4'd9 || bus.out_valid !== 1'b1)
      begin mismatched++; $display("[TB] FAIL t5_reach_idx9 i=%0d v=%b want 9 1", bus.out_index, bus.out_valid); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    compared++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.out_last !== 1'b0 || mem_addr !== 4'd0)
      begin mismatched++; $display("[TB] FAIL t5_abort v=%b busy=%b done=%b l=%b addr=%0d want 0 0 0 0 0",
        bus.out_valid, busy, done, bus.out_last, mem_addr); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compared++;
      if (done !== 1'b0 || bus.out_valid !== 1'b0)
        begin mismatched++; $display("[TB] FAIL t5_no_done done=%b v=%b want 0 0", done, bus.out_valid); end
    end
    start_frame(2'd2);
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd0 || bus.out_data !== mem[0])
      begin mismatched++; $display("[TB] FAIL t5_restart v=%b i=%0d d=%h want 1 0 %h",
        bus.out_valid, bus.out_index, bus.out_data, mem[0]); end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0)
      begin mismatched++; $display("[TB] FAIL t5_abort_beats_start busy=%b v=%b want 0 0", busy, bus.out_valid); end
  endtask

  task automatic test_async_reset;
    fill_random();
    bus.out_ready = 1'b1;
    start_frame(2'd2);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    compared++;
    if ({mem_addr, bus.out_data, bus.out_index, bus.out_valid, bus.out_last, busy, done} !== '0)
      begin mismatched++; $display("[TB] FAIL t6_async_reset addr=%0d d=%h i=%0d v=%b l=%b busy=%b done=%b want all 0",
        mem_addr, bus.out_data, bus.out_index, bus.out_valid, bus.out_last, busy, done); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || bus.out_valid !== 1'b0 || mem_addr !== 4'd0)
        begin mismatched++; $display("[TB] FAIL t6_idle busy=%b v=%b addr=%0d want 0 0 0", busy, bus.out_valid, mem_addr); end
    end
    start_frame(2'd0);
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd0 || bus.out_data !== mem[0])
      begin mismatched++; $display("[TB] FAIL t6_restart v=%b i=%0d d=%h want 1 0 %h",
        bus.out_valid, bus.out_index, bus.out_data, mem[0]); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random_frames;
    int idx;
    int n;
    logic [1:0] m;
    for (int f = 0; f < 6; f++) begin
      fill_random();
      m = 2'($urandom_range(0, 3));
      n = frame_len(m);
      bus.out_ready = 1'b1;
      start_frame(m);
      mode = 2'($urandom);
      idx = 0;
      for (int c = 0; c < 200 && idx < n; c++) begin
        @(negedge clk);
        bus.out_ready = ($urandom_range(0, 9) < 7);
        if (bus.out_valid === 1'b1) begin
          compared++;
          if (bus.out_data !== mem[idx] || bus.out_index !== AW'(idx) || bus.out_last !== (idx == n - 1) ||
              mem_addr !== AW'((idx + 1) % n))
            begin mismatched++; $display("[TB] FAIL rnd_word n=%0d idx=%0d got d=%h i=%0d l=%b addr=%0d want d=%h",
              n, idx, bus.out_data, bus.out_index, bus.out_last, mem_addr, mem[idx]); end
          if (bus.out_ready) idx++;
        end
      end
      @(negedge clk);
      compared++;
      if (idx != n || done !== 1'b1 || busy !== 1'b0)
        begin mismatched++; $display("[TB] FAIL rnd_done n=%0d words=%0d done=%b busy=%b", n, idx, done, busy); end
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
